// File: rtl/rs_div_pkg.sv
// Shared types and helpers for the rs_seq_div restoring divider.
// Operand magnitudes are computed at the widest legal carry chain and sliced by the user.
package rs_div_pkg;

  localparam int MAX_CARRY_CHAIN = 64;
  localparam int DEFAULT_WIDTH   = 32;
  localparam int CNT_W_DEFAULT   = $clog2(DEFAULT_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

  // Magnitude of a width-bit value held in the low bits of a MAX_CARRY_CHAIN word.
  function automatic logic [MAX_CARRY_CHAIN-1:0] abs_w(
    input logic [MAX_CARRY_CHAIN-1:0] value,
    input int unsigned                width,
    input logic                       signed_en
  );
    logic [MAX_CARRY_CHAIN-1:0] mask;
    logic                       sign_bit;
    mask     = {MAX_CARRY_CHAIN{1'b1}} >> (MAX_CARRY_CHAIN - width);
    sign_bit = |(value & ({{(MAX_CARRY_CHAIN-1){1'b0}}, 1'b1} << (width - 1)));
    if (signed_en && sign_bit)
      return (~value + {{(MAX_CARRY_CHAIN-1){1'b0}}, 1'b1}) & mask;
    return value & mask;
  endfunction

endpackage

// File: rtl/rs_div_step.sv
// One restoring-division step: trial subtract of the divisor from the shifted partial remainder.
// Kept as a single plain subtract so synthesis maps it onto the carry chain.
module rs_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   p_shift,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   diff,
  output logic             carry
);

  logic [WIDTH+1:0] sum;

  assign sum   = {1'b0, p_shift} - {2'b00, d};
  assign diff  = sum[WIDTH:0];
  assign carry = ~sum[WIDTH+1];

endmodule

// File: rtl/rs_seq_div.sv
// Iterative restoring divider, one quotient bit per clock, valid/ready on both sides.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand handshake
// RUN   | one shift/subtract step per cycle, WIDTH steps
// FIX   | sign correction or divide-by-zero result loaded into output registers
// DONE  | out_valid high, result held until out_ready
module rs_seq_div
  import rs_div_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int SIGNED = 0
) (
  input  logic             C,
  input  logic             R,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int   CW  = cnt_w(WIDTH);
  localparam logic SGN = (SIGNED != 0);

  div_state_t       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   p_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  logic             sq;
  logic             sr;
  logic             dz;

  logic [WIDTH:0]             p_shift;
  logic [WIDTH:0]             diff;
  logic                       carry;
  logic [MAX_CARRY_CHAIN-1:0] abs_a;
  logic [MAX_CARRY_CHAIN-1:0] abs_b;
  logic                       sa;
  logic                       sb;

  assign in_ready = (state == IDLE);
  assign p_shift  = {p_reg[WIDTH-1:0], q_reg[WIDTH-1]};
  assign abs_a    = abs_w(MAX_CARRY_CHAIN'(dividend), WIDTH, SGN);
  assign abs_b    = abs_w(MAX_CARRY_CHAIN'(divisor), WIDTH, SGN);
  assign sa       = SGN & dividend[WIDTH-1];
  assign sb       = SGN & divisor[WIDTH-1];

  // The partial remainder never exceeds the divisor after a step, so its top bit is never consumed.
  wire unused_bits = ^{abs_a[MAX_CARRY_CHAIN-1:WIDTH], abs_b[MAX_CARRY_CHAIN-1:WIDTH], p_reg[WIDTH]};

  rs_div_step #(.WIDTH(WIDTH)) u_step (
    .p_shift (p_shift),
    .d       (d_reg),
    .diff    (diff),
    .carry   (carry)
  );

  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      state       <= IDLE;
      cnt         <= '0;
      p_reg       <= '0;
      q_reg       <= '0;
      d_reg       <= '0;
      sq          <= 1'b0;
      sr          <= 1'b0;
      dz          <= 1'b0;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sq          <= sa ^ sb;
            sr          <= sa;
            p_reg       <= '0;
            div_by_zero <= 1'b0;
            if (divisor == '0) begin
              // Q holds the raw dividend so FIX can return it unmodified as the remainder.
              dz    <= 1'b1;
              q_reg <= dividend;
              d_reg <= '0;
              state <= FIX;
            end else begin
              dz    <= 1'b0;
              q_reg <= abs_a[WIDTH-1:0];
              d_reg <= abs_b[WIDTH-1:0];
              cnt   <= CW'(WIDTH - 1);
              state <= RUN;
            end
          end
        end
        RUN: begin
          p_reg <= carry ? diff : p_shift;
          q_reg <= {q_reg[WIDTH-2:0], carry};
          if (cnt == '0) state <= FIX;
          else           cnt   <= cnt - CW'(1);
        end
        FIX: begin
          if (dz) begin
            quotient    <= '1;
            remainder   <= q_reg;
            div_by_zero <= 1'b1;
          end else begin
            quotient  <= sq ? -q_reg : q_reg;
            remainder <= sr ? -p_reg[WIDTH-1:0] : p_reg[WIDTH-1:0];
          end
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rs_seq_div.sv
// Bench for rs_seq_div at WIDTH=8: unsigned and signed instances share stimulus,
// a scoreboard queue per instance is filled at the operand handshake and drained at each result accept.
module tb_rs_seq_div;

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] dividend;
  logic [7:0] divisor;

  logic       in_ready_u, uv, dz_u;
  logic [7:0] q_u, r_u;
  logic       in_ready_s, sv, dz_s;
  logic [7:0] q_s, r_s;

  exp_t exp_u[$];
  exp_t exp_s[$];
  int   total;
  int   bad;

  rs_seq_div #(.WIDTH(8), .SIGNED(0)) dut_u (
    .C(clk), .R(rst_n), .in_valid(in_valid), .in_ready(in_ready_u),
    .dividend(dividend), .divisor(divisor), .out_valid(uv), .out_ready(out_ready),
    .quotient(q_u), .remainder(r_u), .div_by_zero(dz_u)
  );

  rs_seq_div #(.WIDTH(8), .SIGNED(1)) dut_s (
    .C(clk), .R(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .dividend(dividend), .divisor(divisor), .out_valid(sv), .out_ready(out_ready),
    .quotient(q_s), .remainder(r_s), .div_by_zero(dz_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input bit sgn);
    exp_t e;
    int   sa;
    int   sb;
    if (b == 8'd0) begin
      e.q  = 8'hFF;
      e.r  = a;
      e.dz = 1'b1;
      return e;
    end
    e.dz = 1'b0;
    if (sgn) begin
      sa  = int'($signed(a));
      sb  = int'($signed(b));
      e.q = 8'(sa / sb);
      e.r = 8'(sa % sb);
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  // Result monitor: out_valid with out_ready at the falling edge means an accept on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && uv === 1'b1 && out_ready === 1'b1) begin
      total++;
      if (exp_u.size() == 0) begin
        bad++;
        $display("FAIL result_u: unexpected result q=%h r=%h, scoreboard empty", q_u, r_u);
      end else begin
        exp_t e;
        e = exp_u.pop_front();
        if ({q_u, r_u, dz_u} !== {e.q, e.r, e.dz}) begin
          bad++;
          $display("FAIL result_u: got q=%h r=%h dz=%b required q=%h r=%h dz=%b",
                   q_u, r_u, dz_u, e.q, e.r, e.dz);
        end
      end
      total++;
      if (exp_s.size() == 0) begin
        bad++;
        $display("FAIL result_s: unexpected result q=%h r=%h, scoreboard empty", q_s, r_s);
      end else begin
        exp_t e;
        e = exp_s.pop_front();
        if ({sv, q_s, r_s, dz_s} !== {1'b1, e.q, e.r, e.dz}) begin
          bad++;
          $display("FAIL result_s: got v=%b q=%h r=%h dz=%b required v=1 q=%h r=%h dz=%b",
                   sv, q_s, r_s, dz_s, e.q, e.r, e.dz);
        end
      end
    end
  end

  // Called at a falling edge with the divider idle; returns at a falling edge with it idle again.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int exp_lat);
    int n;
    n = 0;
    while (in_ready_u !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (in_ready_u !== 1'b1 || in_ready_s !== 1'b1) begin
      bad++;
      $display("FAIL in_ready_wait: in_ready_u=%b in_ready_s=%b required 1", in_ready_u, in_ready_s);
    end
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    exp_u.push_back(model(a, b, 1'b0));
    exp_s.push_back(model(a, b, 1'b1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = 8'($urandom);
    divisor  = 8'($urandom);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (uv !== 1'b1 && n < 40);
    total++;
    if (n != exp_lat) begin
      bad++;
      $display("FAIL latency %0d/%0d: out_valid after %0d cycles required %0d", a, b, n, exp_lat);
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    total++;
    if ({in_ready_u, uv, q_u, r_u, dz_u} !== {1'b1, 1'b0, 8'h00, 8'h00, 1'b0}) begin
      bad++;
      $display("FAIL reset_u: rdy=%b v=%b q=%h r=%h dz=%b required 1 0 00 00 0",
               in_ready_u, uv, q_u, r_u, dz_u);
    end
    total++;
    if ({in_ready_s, sv, q_s, r_s, dz_s} !== {1'b1, 1'b0, 8'h00, 8'h00, 1'b0}) begin
      bad++;
      $display("FAIL reset_s: rdy=%b v=%b q=%h r=%h dz=%b required 1 0 00 00 0",
               in_ready_s, sv, q_s, r_s, dz_s);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_unsigned;
    run_op(8'd200, 8'd7, 10);
    run_op(8'd0, 8'd5, 10);
    run_op(8'd255, 8'd255, 10);
    run_op(8'd1, 8'd255, 10);
    run_op(8'd255, 8'd1, 10);
    run_op(8'd6, 8'd3, 10);
  endtask

  task automatic test_signed;
    run_op(8'hF9, 8'h02, 10);
    run_op(8'h07, 8'hFE, 10);
    run_op(8'h80, 8'hFF, 10);
    run_op(8'h80, 8'h01, 10);
    run_op(8'h7F, 8'h80, 10);
  endtask

  task automatic test_div_zero;
    run_op(8'd13, 8'd0, 2);
    run_op(8'd200, 8'd7, 10);
    run_op(8'h80, 8'd0, 2);
  endtask

  task automatic test_backpressure;
    int n;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    dividend  = 8'd100;
    divisor   = 8'd9;
    exp_u.push_back(model(8'd100, 8'd9, 1'b0));
    exp_s.push_back(model(8'd100, 8'd9, 1'b1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (uv !== 1'b1 && n < 40);
    total++;
    if (uv !== 1'b1) begin
      bad++;
      $display("FAIL bp_wait: out_valid=%b required 1 within 40 cycles", uv);
    end
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({uv, q_u, r_u, in_ready_u, q_s, r_s} !== {1'b1, 8'd11, 8'd1, 1'b0, 8'd11, 8'd1}) begin
        bad++;
        $display("FAIL bp_hold[%0d]: v=%b q=%h r=%h rdy=%b qs=%h rs=%h required 1 0b 01 0 0b 01",
                 i, uv, q_u, r_u, in_ready_u, q_s, r_s);
      end
      in_valid = 1'b1;
      dividend = 8'd50;
      divisor  = 8'd5;
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({uv, in_ready_u, in_ready_s} !== 3'b011) begin
      bad++;
      $display("FAIL bp_release: v=%b rdy_u=%b rdy_s=%b required 0 1 1", uv, in_ready_u, in_ready_s);
    end
    total++;
    if (exp_u.size() != 0) begin
      bad++;
      $display("FAIL bp_single_accept: %0d results pending required 0", exp_u.size());
    end
  endtask

  task automatic test_reset_mid_run;
    in_valid = 1'b1;
    dividend = 8'd200;
    divisor  = 8'd7;
    exp_u.push_back(model(8'd200, 8'd7, 1'b0));
    exp_s.push_back(model(8'd200, 8'd7, 1'b1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if ({in_ready_u, uv, q_u, r_u, dz_u} !== {1'b1, 1'b0, 8'h00, 8'h00, 1'b0}) begin
      bad++;
      $display("FAIL mid_reset_u: rdy=%b v=%b q=%h r=%h dz=%b required 1 0 00 00 0",
               in_ready_u, uv, q_u, r_u, dz_u);
    end
    @(negedge clk);
    total++;
    if ({in_ready_s, sv, q_s, r_s, dz_s} !== {1'b1, 1'b0, 8'h00, 8'h00, 1'b0}) begin
      bad++;
      $display("FAIL mid_reset_s: rdy=%b v=%b q=%h r=%h dz=%b required 1 0 00 00 0",
               in_ready_s, sv, q_s, r_s, dz_s);
    end
    rst_n = 1'b1;
    exp_u.delete();
    exp_s.delete();
    @(negedge clk);
    run_op(8'd255, 8'd1, 10);
  endtask

  task automatic test_random;
    logic [7:0] a;
    logic [7:0] b;
    for (int i = 0; i < 250; i++) begin
      a = 8'($urandom);
      b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
      run_op(a, b, (b == 8'd0) ? 2 : 10);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    dividend  = 8'd0;
    divisor   = 8'd0;
    repeat (3) @(negedge clk);
    test_reset;
    test_unsigned;
    test_signed;
    test_div_zero;
    test_backpressure;
    test_reset_mid_run;
    test_random;
    total++;
    if (exp_u.size() != 0 || exp_s.size() != 0) begin
      bad++;
      $display("FAIL drain: pending u=%0d s=%0d required 0", exp_u.size(), exp_s.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
